dbg_sysclk_cmd_bridge: RTL and testbench

DBG_SYSCLK_CMD_BRIDGE -- requirements
Module: dbg_sysclk_cmd_bridge

---
 rtl/dbg_bridge_pkg.sv | 14 +
 rtl/dbg_sync_edge.sv | 41 ++++
 rtl/dbg_sysclk_cmd_bridge.sv | 106 ++++++++++
 tb/tb_dbg_sysclk_cmd_bridge.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_bridge_pkg.sv
// Shared definitions for the debug command bridge: default geometry and the
// command FSM state type.
package dbg_bridge_pkg;

  localparam int SR_W_DEF        = 38;
  localparam int IR_W_DEF        = 2;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } bridge_state_e;

endpackage

// File: rtl/dbg_sync_edge.sv
// Level synchroniser plus rising-edge detector for a tck-domain strobe.
// After reset the detector stays disarmed until the whole synchroniser chain
// and the edge-history flop hold real samples. A strobe that is already high
// when reset is released therefore never looks like a fresh rising edge.
module dbg_sync_edge
  import dbg_bridge_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise
);

  localparam int               CNT_W     = $clog2(STAGES + 2);
  localparam logic [CNT_W-1:0] WARM_DONE = CNT_W'(STAGES + 1);

  logic [STAGES-1:0] sync_p;
  logic              prev_p;
  logic [CNT_W-1:0]  warm_cnt;
  logic              armed;

  assign armed = (warm_cnt == WARM_DONE);

  // Synchroniser chain, edge-history flop and post-reset warm-up counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p   <= '0;
      prev_p   <= 1'b0;
      warm_cnt <= '0;
    end else begin
      sync_p <= {sync_p[STAGES-2:0], async_in};
      prev_p <= sync_p[STAGES-1];
      if (!armed) warm_cnt <= warm_cnt + CNT_W'(1);
    end
  end

  assign rise = armed & sync_p[STAGES-1] & ~prev_p;

endmodule

// File: rtl/dbg_sysclk_cmd_bridge.sv
// JTAG update-DR / update-IR to system-clock command bridge.
// The update strobes are synchronised and edge-detected. The shift register
// and instruction are sampled unsynchronised on the detected update-DR edge;
// this relies on them being quasi-static around the update.
// The captured command is held until the consumer accepts it. At acceptance,
// one channel pulse is raised on take_action or take_no_action, depending on
// the command MSB.
// Optional feature: define DBG_SYSCLK_CMD_BRIDGE_OVERRUN_EN to get a sticky
// overrun flag for commands dropped while one is still pending. Without it,
// overrun is constant 0 and dropped commands go unreported.
module dbg_sysclk_cmd_bridge
  import dbg_bridge_pkg::*;
#(
  parameter int SR_W        = SR_W_DEF,
  parameter int IR_W        = IR_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [SR_W-1:0]      sr,
  input  logic [IR_W-1:0]      ir_in,
  input  logic                 vs_udr,
  input  logic                 vs_uir,
  input  logic                 cmd_ready,
  output logic [SR_W-1:0]      jdo,
  output logic [IR_W-1:0]      cmd_ir,
  output logic                 cmd_valid,
  output logic [(2**IR_W)-1:0] take_action,
  output logic [(2**IR_W)-1:0] take_no_action,
  output logic                 ir_update,
  output logic                 overrun
);

  localparam int NCH = 2**IR_W;

  bridge_state_e  state;
  logic           udr_edge;
  logic           uir_edge;
  logic           accept;
  logic [NCH-1:0] ch_sel;

  dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_udr_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (vs_udr),
    .rise     (udr_edge)
  );

  dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_uir_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (vs_uir),
    .rise     (uir_edge)
  );

  // Command FSM: capture on update-DR edge, hold until accepted.
  // When an accept and a new edge land in the same cycle, the slot is handed
  // straight to the new command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cmd_valid <= 1'b0;
      jdo       <= '0;
      cmd_ir    <= '0;
    end else if (state == ST_IDLE) begin
      if (udr_edge) begin
        jdo       <= sr;
        cmd_ir    <= ir_in;
        state     <= ST_PEND;
        cmd_valid <= 1'b1;
      end
    end else begin
      if (cmd_ready) begin
        if (udr_edge) begin
          jdo    <= sr;
          cmd_ir <= ir_in;
        end else begin
          state     <= ST_IDLE;
          cmd_valid <= 1'b0;
        end
      end
    end
  end

  // Instruction-update pulse, independent of the command FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ir_update <= 1'b0;
    else          ir_update <= uir_edge;
  end

`ifdef DBG_SYSCLK_CMD_BRIDGE_OVERRUN_EN
  // Sticky flag: a new command arrived while the previous one was unaccepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                 overrun <= 1'b0;
    else if (cmd_valid && udr_edge && !cmd_ready) overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif

  assign accept         = cmd_valid & cmd_ready;
  assign ch_sel         = NCH'(1) << cmd_ir;
  assign take_action    = (accept &&  jdo[SR_W-1]) ? ch_sel : '0;
  assign take_no_action = (accept && !jdo[SR_W-1]) ? ch_sel : '0;

endmodule

// File: tb/tb_dbg_sysclk_cmd_bridge.sv
// Testbench for dbg_sysclk_cmd_bridge: vector table, hand sequences and a
// randomized run against a behavioural model.
module tb_dbg_sysclk_cmd_bridge;
  import dbg_bridge_pkg::*;

  localparam int SR_W = 38;
  localparam int IR_W = 2;
  localparam int S    = 2;
  localparam int NCH  = 4;
`ifdef DBG_SYSCLK_CMD_BRIDGE_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic            clk;
  logic            reset_n;
  logic [SR_W-1:0] sr;
  logic [IR_W-1:0] ir_in;
  logic            vs_udr;
  logic            vs_uir;
  logic            cmd_ready;
  logic [SR_W-1:0] jdo;
  logic [IR_W-1:0] cmd_ir;
  logic            cmd_valid;
  logic [NCH-1:0]  take_action;
  logic [NCH-1:0]  take_no_action;
  logic            ir_update;
  logic            overrun;

  dbg_sysclk_cmd_bridge #(.SR_W(SR_W), .IR_W(IR_W), .SYNC_STAGES(S)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sr             (sr),
    .ir_in          (ir_in),
    .vs_udr         (vs_udr),
    .vs_uir         (vs_uir),
    .cmd_ready      (cmd_ready),
    .jdo            (jdo),
    .cmd_ir         (cmd_ir),
    .cmd_valid      (cmd_valid),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .ir_update      (ir_update),
    .overrun        (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The bridge sees each strobe level S clocks late. A command edge is a
  // 0->1 step in that delayed view. Steps that involve samples from before
  // reset release do not count.
  bit              udr_h[$];
  bit              uir_h[$];
  bit              m_pend, m_ovr, m_irupd;
  logic [SR_W-1:0] m_jdo;
  logic [IR_W-1:0] m_ir;

  function automatic bit late_rise(input bit h[$]);
    int n = h.size();
    if (n < S + 1) return 1'b0;
    return h[n-S] && !h[n-S-1];
  endfunction

  task automatic model_reset();
    udr_h.delete();
    uir_h.delete();
    m_pend  = 0;
    m_ovr   = 0;
    m_irupd = 0;
    m_jdo   = '0;
    m_ir    = '0;
  endtask

  task automatic model_step();
    bit ue, ie;
    ue = late_rise(udr_h);
    ie = late_rise(uir_h);
    udr_h.push_back(vs_udr);
    uir_h.push_back(vs_uir);
    m_irupd = ie;
    if (ue && (!m_pend || cmd_ready)) begin
      m_jdo  = sr;
      m_ir   = ir_in;
      m_pend = 1;
    end else if (m_pend && cmd_ready) begin
      m_pend = 0;
    end else if (m_pend && ue) begin
      m_ovr = m_ovr | OVR_EN;
    end
  endtask

  task automatic model_check();
    logic [NCH-1:0] ch, ta, tna;
    ch  = NCH'(1) << m_ir;
    ta  = (m_pend && cmd_ready &&  m_jdo[SR_W-1]) ? ch : '0;
    tna = (m_pend && cmd_ready && !m_jdo[SR_W-1]) ? ch : '0;
    check("rnd_cmd_valid", 64'(cmd_valid), 64'(m_pend));
    if (m_pend) begin
      check("rnd_jdo", 64'(jdo), 64'(m_jdo));
      check("rnd_cmd_ir", 64'(cmd_ir), 64'(m_ir));
    end
    check("rnd_take_action", 64'(take_action), 64'(ta));
    check("rnd_take_no_action", 64'(take_no_action), 64'(tna));
    check("rnd_ir_update", 64'(ir_update), 64'(m_irupd));
    check("rnd_overrun", 64'(overrun), 64'(m_ovr));
  endtask

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    vs_udr = 0; vs_uir = 0; cmd_ready = 0;
    #1;
    check("rst_outputs",
          64'({cmd_valid, take_action, take_no_action, ir_update, overrun}), 64'd0);
    check("rst_jdo", 64'(jdo), 64'd0);
    check("rst_cmd_ir", 64'(cmd_ir), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic pulse(input logic [SR_W-1:0] s, input logic [IR_W-1:0] i, input int len);
    sr = s; ir_in = i; vs_udr = 1'b1;
    repeat (len) @(negedge clk);
    vs_udr = 1'b0;
  endtask

  typedef struct {
    logic [SR_W-1:0] sr;
    logic [IR_W-1:0] ir;
    int              len;
    int              delay;
    logic [NCH-1:0]  exp_ta;
    logic [NCH-1:0]  exp_tna;
  } vec_t;

  vec_t vecs[4];

  // Call at a negedge with the bridge idle and vs_udr low
  task automatic run_vec(input vec_t v, input int idx);
    int t;
    sr = v.sr; ir_in = v.ir; vs_udr = 1'b1; cmd_ready = 1'b0;
    t = 0;
    #1 check($sformatf("v%0d_valid_e0", idx), 64'(cmd_valid), 64'd0);
    for (int c = 1; c <= S; c++) begin
      @(negedge clk); t++;
      if (t >= v.len) vs_udr = 1'b0;
      #1 check($sformatf("v%0d_valid_e%0d", idx, c), 64'(cmd_valid), 64'd0);
    end
    for (int h = 0; h <= v.delay; h++) begin
      @(negedge clk); t++;
      if (t >= v.len) vs_udr = 1'b0;
      cmd_ready = (h == v.delay);
      #1;
      check($sformatf("v%0d_valid_h%0d", idx, h), 64'(cmd_valid), 64'd1);
      check($sformatf("v%0d_jdo_h%0d", idx, h), 64'(jdo), 64'(v.sr));
      check($sformatf("v%0d_ir_h%0d", idx, h), 64'(cmd_ir), 64'(v.ir));
      check($sformatf("v%0d_ta_h%0d", idx, h), 64'(take_action),
            (h == v.delay) ? 64'(v.exp_ta) : 64'd0);
      check($sformatf("v%0d_tna_h%0d", idx, h), 64'(take_no_action),
            (h == v.delay) ? 64'(v.exp_tna) : 64'd0);
    end
    @(negedge clk);
    vs_udr = 1'b0; cmd_ready = 1'b0;
    #1 check($sformatf("v%0d_valid_done", idx), 64'(cmd_valid), 64'd0);
    repeat (S + 3) @(negedge clk);
  endtask

  int udr_left, udr_gap, uir_left, uir_gap;

  initial begin
    reset_n = 1'b0; sr = '0; ir_in = '0; vs_udr = 0; vs_uir = 0; cmd_ready = 0;

    vecs[0] = '{38'h20_0000_1234, 2'd2, 3, 0,  4'b0100, 4'b0000};
    vecs[1] = '{38'h00_0000_5678, 2'd1, 1, 0,  4'b0000, 4'b0010};
    vecs[2] = '{38'h3F_FFFF_FFFF, 2'd3, 2, 10, 4'b1000, 4'b0000};
    vecs[3] = '{38'h00_0000_0000, 2'd0, 3, 3,  4'b0000, 4'b0001};

    do_reset();
    repeat (S + 4) @(negedge clk);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Update-IR: a single pulse one clock after its edge is synchronised
    vs_uir = 1'b1;
    for (int c = 1; c <= S + 4; c++) begin
      @(negedge clk);
      if (c == 3) vs_uir = 1'b0;
      #1 check($sformatf("irupd_c%0d", c), 64'(ir_update), (c == S + 1) ? 64'd1 : 64'd0);
    end
    repeat (3) @(negedge clk);

    // Overrun: second command while the first is pending is dropped
    cmd_ready = 1'b0;
    pulse(38'h2F_0000_AAAA, 2'd3, 2);
    repeat (S + 2) @(negedge clk);
    #1 check("ovr_first_valid", 64'(cmd_valid), 64'd1);
    pulse(38'h01_5555_0000, 2'd0, 2);
    repeat (S + 2) @(negedge clk);
    #1;
    check("ovr_jdo_kept", 64'(jdo), 64'h2F_0000_AAAA);
    check("ovr_ir_kept", 64'(cmd_ir), 64'd3);
    check("ovr_flag", 64'(overrun), 64'(OVR_EN));
    cmd_ready = 1'b1;
    #1 check("ovr_take", 64'({take_action, take_no_action}), 64'({4'b1000, 4'b0000}));
    @(negedge clk);
    cmd_ready = 1'b0;
    #1;
    check("ovr_valid_clr", 64'(cmd_valid), 64'd0);
    check("ovr_sticky", 64'(overrun), 64'(OVR_EN));
    do_reset();
    repeat (S + 4) @(negedge clk);
    #1 check("ovr_cleared", 64'(overrun), 64'd0);

    // Simultaneous accept and new edge: old pulses, new becomes pending
    pulse(38'h00_1111_2222, 2'd0, 1);
    repeat (S + 2) @(negedge clk);
    #1 check("sim_first_valid", 64'(cmd_valid), 64'd1);
    @(negedge clk);
    sr = 38'h2A_BCDE_F012; ir_in = 2'd2; vs_udr = 1'b1;
    @(negedge clk);
    vs_udr = 1'b0;
    repeat (S - 1) @(negedge clk);
    cmd_ready = 1'b1;
    #1;
    check("sim_tna_old", 64'(take_no_action), 64'b0001);
    check("sim_ta_old", 64'(take_action), 64'd0);
    @(negedge clk);
    cmd_ready = 1'b0;
    #1;
    check("sim_valid_new", 64'(cmd_valid), 64'd1);
    check("sim_jdo_new", 64'(jdo), 64'h2A_BCDE_F012);
    check("sim_ir_new", 64'(cmd_ir), 64'd2);
    check("sim_no_overrun", 64'(overrun), 64'd0);
    check("sim_no_pulse", 64'({take_action, take_no_action}), 64'd0);
    cmd_ready = 1'b1;
    #1 check("sim_ta_new", 64'(take_action), 64'b0100);
    @(negedge clk);
    cmd_ready = 1'b0;
    #1 check("sim_valid_done", 64'(cmd_valid), 64'd0);
    repeat (S + 3) @(negedge clk);

    // Reset mid-pending with vs_udr held high across release
    pulse(38'h30_0000_0001, 2'd1, 1);
    repeat (S + 2) @(negedge clk);
    #1 check("rstp_valid", 64'(cmd_valid), 64'd1);
    @(negedge clk);
    sr = 38'h3C_0000_0002; vs_udr = 1'b1; cmd_ready = 1'b1;
    #1 check("rstp_take_before", 64'(take_action), 64'b0010);
    reset_n = 1'b0;
    #1;
    check("rstp_outputs", 64'({cmd_valid, take_action, take_no_action, ir_update, overrun}), 64'd0);
    check("rstp_jdo", 64'(jdo), 64'd0);
    check("rstp_cmd_ir", 64'(cmd_ir), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1 check($sformatf("rstp_quiet_c%0d", c),
               64'({cmd_valid, take_action, take_no_action}), 64'd0);
    end
    vs_udr = 1'b0; cmd_ready = 1'b0;
    repeat (S + 3) @(negedge clk);
    run_vec(vecs[0], 10);

    // Randomized run against the model
    do_reset();
    udr_left = 0; udr_gap = 3; uir_left = 0; uir_gap = 5;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (udr_left > 0) begin
        udr_left--;
        if (udr_left == 0) begin
          vs_udr  = 1'b0;
          udr_gap = $urandom_range(S + 2, 10);
        end
      end else if (udr_gap > 0) begin
        udr_gap--;
      end else begin
        sr       = {6'($urandom), 32'($urandom)};
        ir_in    = 2'($urandom);
        vs_udr   = 1'b1;
        udr_left = $urandom_range(1, 6);
      end
      if (uir_left > 0) begin
        uir_left--;
        if (uir_left == 0) begin
          vs_uir  = 1'b0;
          uir_gap = $urandom_range(1, 8);
        end
      end else if (uir_gap > 0) begin
        uir_gap--;
      end else begin
        vs_uir   = 1'b1;
        uir_left = $urandom_range(1, 4);
      end
      cmd_ready = ($urandom_range(0, 9) < 3);
      #1 model_check();
      model_step();
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
